dino_motion_ctrl: RTL and testbench



---
 rtl/dino_motion_ctrl.sv | 152 +++++++++++++++
 tb/tb_dino_motion_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_motion_ctrl.sv
// Dino sprite motion controller: turns up/down buttons into a per-frame sprite position
// with a run/jump/duck state machine. Optional macro: DINO_DOUBLE_JUMP_EN (one mid-air re-jump).
module dino_motion_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        up,
  input  logic        down,
  input  logic        hold,
  output logic [31:0] dino_x,
  output logic [31:0] dino_y,
  output logic        airborne,
  output logic        ducking
);

  localparam int unsigned GROUND   = 335;
  localparam int unsigned SPRITE_H = 60;
  localparam int unsigned REST_Y   = GROUND - SPRITE_H;
  localparam int unsigned X_POS    = 30;
  localparam int unsigned JUMP_V   = 14;
  localparam int unsigned GRAVITY  = 1;
  localparam int unsigned VEL_MAX  = 63;

  localparam logic        [9:0]  REST_Y_U  = 10'(REST_Y);
  localparam logic signed [10:0] REST_Y_S  = 11'(REST_Y);
  localparam logic signed [10:0] VEL_MAX_S = 11'(VEL_MAX);
  localparam logic signed [7:0]  VEL_JUMP  = 8'(-int'(JUMP_V));

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_AIR  = 2'b01,
    ST_DUCK = 2'b10
  } state_t;

  state_t             state, state_next;
  logic        [9:0]  y, y_next;
  logic signed [7:0]  vel, vel_next;
  logic               jump_pending, pending_next;
  logic               up_meta, up_sync, down_meta, down_sync;
  logic               tick_prev, tick;
  logic signed [10:0] y_ext, vel_ext, g, y_sum, vel_sum;
`ifdef DINO_DOUBLE_JUMP_EN
  logic               dj_used, dj_next;
`endif

  assign tick   = frame_tick & ~tick_prev;
  assign dino_x = 32'(X_POS);
  assign dino_y = 32'(y);

  // Next-state and kinematics; only tick cycles without hold move the sprite.
  always_comb begin
    state_next   = state;
    y_next       = y;
    vel_next     = vel;
    pending_next = jump_pending;
`ifdef DINO_DOUBLE_JUMP_EN
    dj_next      = dj_used;
`endif
    y_ext   = signed'(11'(y));
    vel_ext = 11'(vel);
    g       = down_sync ? 11'(2 * GRAVITY) : 11'(GRAVITY);
    y_sum   = y_ext + vel_ext;
    vel_sum = vel_ext + g;

    if (hold || tick) begin
      pending_next = 1'b0;
    end else if (up_sync) begin
      pending_next = 1'b1;
    end

    if (tick && !hold) begin
      unique case (state)
        ST_RUN: begin
          if (jump_pending) begin
            state_next = ST_AIR;
            vel_next   = VEL_JUMP;
          end else if (down_sync) begin
            state_next = ST_DUCK;
          end
        end
        ST_DUCK: begin
          y_next = REST_Y_U;
          if (jump_pending) begin
            state_next = ST_AIR;
            vel_next   = VEL_JUMP;
          end else if (!down_sync) begin
            state_next = ST_RUN;
          end
        end
        ST_AIR: begin
`ifdef DINO_DOUBLE_JUMP_EN
          if (jump_pending && !dj_used) begin
            vel_next = VEL_JUMP;
            dj_next  = 1'b1;
          end else
`endif
          if (vel > 8'sd0 && y_sum >= REST_Y_S) begin
            y_next     = REST_Y_U;
            vel_next   = 8'sd0;
            state_next = ST_RUN;
`ifdef DINO_DOUBLE_JUMP_EN
            dj_next    = 1'b0;
`endif
          end else if (y_sum < 11'sd0) begin
            y_next   = 10'd0;
            vel_next = 8'sd0;
          end else begin
            y_next   = 10'(y_sum);
            vel_next = (vel_sum > VEL_MAX_S) ? 8'(VEL_MAX) : 8'(vel_sum);
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  // State, datapath, synchronizers and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      y            <= REST_Y_U;
      vel          <= 8'sd0;
      jump_pending <= 1'b0;
      up_meta      <= 1'b0;
      up_sync      <= 1'b0;
      down_meta    <= 1'b0;
      down_sync    <= 1'b0;
      tick_prev    <= 1'b0;
      airborne     <= 1'b0;
      ducking      <= 1'b0;
`ifdef DINO_DOUBLE_JUMP_EN
      dj_used      <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      y            <= y_next;
      vel          <= vel_next;
      jump_pending <= pending_next;
      up_meta      <= up;
      up_sync      <= up_meta;
      down_meta    <= down;
      down_sync    <= down_meta;
      tick_prev    <= frame_tick;
      airborne     <= (state_next == ST_AIR);
      ducking      <= (state_next == ST_DUCK);
`ifdef DINO_DOUBLE_JUMP_EN
      dj_used      <= dj_next;
`endif
    end
  end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Scoreboard bench for dino_motion_ctrl: a behavioural model pushes the expected
// position/status per frame tick, popped and compared after the DUT updates.
module tb_dino_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset, frame_tick, up, down, hold;
  logic [31:0] dino_x, dino_y;
  logic        airborne, ducking;

  dino_motion_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down), .hold(hold),
    .dino_x(dino_x), .dino_y(dino_y), .airborne(airborne), .ducking(ducking)
  );

  always #5 clk = ~clk;

`ifdef DINO_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  typedef struct { int y; logic air; logic duck; } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model (0=run, 1=air, 2=duck)
  int m_y = 275, m_vel = 0, m_st = 0;
  bit m_pending = 0, m_down = 0, m_hold = 0, m_dj = 0;

  task automatic model_reset();
    m_y = 275; m_vel = 0; m_st = 0; m_pending = 0; m_dj = 0;
  endtask

  task automatic model_step();
    int g, ny;
    if (!m_hold) begin
      case (m_st)
        0: if (m_pending) begin m_st = 1; m_vel = -14; end
           else if (m_down) m_st = 2;
        2: if (m_pending) begin m_st = 1; m_vel = -14; end
           else if (!m_down) m_st = 0;
        default: begin
          if (DJ && m_pending && !m_dj) begin
            m_vel = -14; m_dj = 1;
          end else begin
            g  = m_down ? 2 : 1;
            ny = m_y + m_vel;
            if (m_vel > 0 && ny >= 275) begin m_y = 275; m_vel = 0; m_st = 0; m_dj = 0; end
            else if (ny < 0) begin m_y = 0; m_vel = 0; end
            else begin m_y = ny; m_vel = (m_vel + g > 63) ? 63 : m_vel + g; end
          end
        end
      endcase
    end
    m_pending = 0;
  endtask

  task automatic press_up();
    up = 1'b1;
    repeat (3) @(posedge clk);
    #1 up = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (!m_hold) m_pending = 1;
  endtask

  task automatic set_down(input bit v);
    down = v;
    repeat (3) @(posedge clk);
    #1 m_down = v;
  endtask

  task automatic set_hold(input bit v);
    hold = v; m_hold = v;
    if (v) m_pending = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_tick(input int len);
    model_step();
    sb.push_back('{m_y, (m_st == 1), (m_st == 2)});
    frame_tick = 1'b1;
    repeat (len) @(posedge clk);
    #1 frame_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (dino_x !== 32'd30 || dino_y !== 32'd275 || airborne !== 1'b0 || ducking !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got x=%0d y=%0d air=%0b duck=%0b, want x=30 y=275 air=0 duck=0",
               dino_x, dino_y, airborne, ducking);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (dino_y !== 32'd275 || airborne !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got y=%0d air=%0b, want y=275 air=0", dino_y, airborne);
    end
  endtask

  task automatic test_jump_arc();
    press_up();
    do_tick(1);
    e = sb.pop_front();
    n_tests++;
    if (dino_y !== 32'd275 || airborne !== 1'b1 || e.y != 275) begin
      n_fail++;
      $display("FAIL arc_takeoff: got y=%0d air=%0b, want y=275 air=1", dino_y, airborne);
    end
    for (int i = 1; i <= 29; i++) begin
      do_tick(1);
      e = sb.pop_front();
      n_tests++;
      if (dino_y !== 32'(e.y) || airborne !== e.air || ducking !== e.duck) begin
        n_fail++;
        $display("FAIL arc_tick%0d: got y=%0d air=%0b duck=%0b, want y=%0d air=%0b duck=%0b",
                 i, dino_y, airborne, ducking, e.y, e.air, e.duck);
      end
      if (i == 1 || i == 14 || i == 29) begin
        n_tests++;
        if (dino_y !== ((i == 1) ? 32'd261 : (i == 14) ? 32'd170 : 32'd275) ||
            airborne !== (i != 29)) begin
          n_fail++;
          $display("FAIL arc_point%0d: got y=%0d air=%0b", i, dino_y, airborne);
        end
      end
    end
  endtask

  task automatic test_fast_fall();
    int fall_y[4];
    fall_y = '{170, 172, 176, 182};
    press_up();
    for (int i = 0; i <= 14; i++) begin
      do_tick(1);
      e = sb.pop_front();
      n_tests++;
      if (dino_y !== 32'(e.y) || airborne !== e.air) begin
        n_fail++;
        $display("FAIL ff_rise%0d: got y=%0d air=%0b, want y=%0d air=%0b", i, dino_y, airborne, e.y, e.air);
      end
    end
    n_tests++;
    if (dino_y !== 32'd170) begin
      n_fail++;
      $display("FAIL ff_apex: got y=%0d, want 170", dino_y);
    end
    set_down(1'b1);
    for (int k = 0; k < 40; k++) begin
      do_tick(1);
      e = sb.pop_front();
      n_tests++;
      if (dino_y !== 32'(e.y) || airborne !== e.air || ducking !== e.duck ||
          (k < 4 && dino_y !== 32'(fall_y[k]))) begin
        n_fail++;
        $display("FAIL ff_fall%0d: got y=%0d air=%0b duck=%0b, want y=%0d air=%0b duck=%0b",
                 k, dino_y, airborne, ducking, e.y, e.air, e.duck);
      end
      if (m_st == 0) break;
    end
    n_tests++;
    if (dino_y !== 32'd275 || airborne !== 1'b0 || ducking !== 1'b0) begin
      n_fail++;
      $display("FAIL ff_landed: got y=%0d air=%0b duck=%0b, want y=275 air=0 duck=0", dino_y, airborne, ducking);
    end
    set_down(1'b0);
  endtask

  task automatic test_duck();
    set_down(1'b1);
    do_tick(1);
    e = sb.pop_front();
    n_tests++;
    if (ducking !== 1'b1 || dino_y !== 32'd275 || ducking !== e.duck || airborne !== e.air) begin
      n_fail++;
      $display("FAIL duck_enter: got y=%0d duck=%0b air=%0b, want y=275 duck=1 air=0", dino_y, ducking, airborne);
    end
    set_down(1'b0);
    do_tick(1);
    e = sb.pop_front();
    n_tests++;
    if (ducking !== 1'b0 || dino_y !== 32'd275 || ducking !== e.duck) begin
      n_fail++;
      $display("FAIL duck_exit: got y=%0d duck=%0b, want y=275 duck=0", dino_y, ducking);
    end
  endtask

  task automatic test_long_tick();
    press_up();
    do_tick(4);
    e = sb.pop_front();
    n_tests++;
    if (dino_y !== 32'd275 || airborne !== 1'b1 || airborne !== e.air) begin
      n_fail++;
      $display("FAIL long_tick_takeoff: got y=%0d air=%0b, want y=275 air=1", dino_y, airborne);
    end
    do_tick(4);
    e = sb.pop_front();
    n_tests++;
    if (dino_y !== 32'd261 || dino_y !== 32'(e.y)) begin
      n_fail++;
      $display("FAIL long_tick_single_step: got y=%0d, want 261", dino_y);
    end
    for (int k = 0; k < 40 && m_st != 0; k++) begin
      do_tick(1);
      e = sb.pop_front();
      n_tests++;
      if (dino_y !== 32'(e.y) || airborne !== e.air) begin
        n_fail++;
        $display("FAIL long_tick_fall%0d: got y=%0d air=%0b, want y=%0d air=%0b", k, dino_y, airborne, e.y, e.air);
      end
    end
    n_tests++;
    if (airborne !== 1'b0 || dino_y !== 32'd275) begin
      n_fail++;
      $display("FAIL long_tick_landed: got y=%0d air=%0b, want y=275 air=0", dino_y, airborne);
    end
  endtask

  task automatic test_hold();
    set_hold(1'b1);
    up = 1'b1;
    for (int k = 0; k < 10; k++) begin
      do_tick(1);
      e = sb.pop_front();
      n_tests++;
      if (dino_y !== 32'(e.y) || airborne !== e.air || ducking !== e.duck || dino_y !== 32'd275) begin
        n_fail++;
        $display("FAIL hold_tick%0d: got y=%0d air=%0b duck=%0b, want y=%0d air=%0b duck=%0b",
                 k, dino_y, airborne, ducking, e.y, e.air, e.duck);
      end
    end
    up = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    set_hold(1'b0);
    do_tick(1);
    e = sb.pop_front();
    n_tests++;
    if (airborne !== 1'b0 || dino_y !== 32'd275 || airborne !== e.air) begin
      n_fail++;
      $display("FAIL hold_no_jump: got y=%0d air=%0b, want y=275 air=0", dino_y, airborne);
    end
  endtask

  task automatic test_double_jump();
    press_up();
    do_tick(1);
    void'(sb.pop_front());
    for (int k = 0; k < 10 && m_y > 210; k++) begin
      do_tick(1);
      e = sb.pop_front();
      n_tests++;
      if (dino_y !== 32'(e.y) || airborne !== e.air) begin
        n_fail++;
        $display("FAIL dj_rise%0d: got y=%0d air=%0b, want y=%0d air=%0b", k, dino_y, airborne, e.y, e.air);
      end
    end
    press_up();
    do_tick(1);
    void'(sb.pop_front());
    do_tick(1);
    e = sb.pop_front();
    n_tests++;
`ifdef DINO_DOUBLE_JUMP_EN
    if (dino_y !== 32'd192) begin
      n_fail++;
      $display("FAIL dj_second_press: got y=%0d, want 192", dino_y);
    end
`else
    if (dino_y !== 32'd191) begin
      n_fail++;
      $display("FAIL dj_second_press: got y=%0d, want 191", dino_y);
    end
`endif
    press_up();
    for (int k = 0; k < 80 && m_st != 0; k++) begin
      do_tick(1);
      e = sb.pop_front();
      n_tests++;
      if (dino_y !== 32'(e.y) || airborne !== e.air) begin
        n_fail++;
        $display("FAIL dj_flight%0d: got y=%0d air=%0b, want y=%0d air=%0b", k, dino_y, airborne, e.y, e.air);
      end
    end
    n_tests++;
    if (airborne !== 1'b0 || dino_y !== 32'd275) begin
      n_fail++;
      $display("FAIL dj_landed: got y=%0d air=%0b, want y=275 air=0", dino_y, airborne);
    end
  endtask

  task automatic test_reset_mid_jump();
    press_up();
    for (int k = 0; k < 6; k++) begin
      do_tick(1);
      void'(sb.pop_front());
    end
    n_tests++;
    if (dino_y !== 32'd215 || airborne !== 1'b1) begin
      n_fail++;
      $display("FAIL midjump_pre: got y=%0d air=%0b, want y=215 air=1", dino_y, airborne);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if (dino_y !== 32'd275 || airborne !== 1'b0 || ducking !== 1'b0 || dino_x !== 32'd30) begin
      n_fail++;
      $display("FAIL midjump_async_reset: got x=%0d y=%0d air=%0b duck=%0b, want x=30 y=275 air=0 duck=0",
               dino_x, dino_y, airborne, ducking);
    end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    do_tick(1);
    e = sb.pop_front();
    n_tests++;
    if (dino_y !== 32'(e.y) || airborne !== e.air || airborne !== 1'b0) begin
      n_fail++;
      $display("FAIL midjump_after: got y=%0d air=%0b, want y=%0d air=0", dino_y, airborne, e.y);
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; up = 1'b0; down = 1'b0; hold = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_jump_arc();
    test_fast_fall();
    test_duck();
    test_long_tick();
    test_hold();
    test_double_jump();
    test_reset_mid_jump();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
